// File: rtl/rr_backup_buffer.sv
// Per-core register-file backup with a commit-delay pipeline and a replay FSM.
// Optional shadow parity is enabled with the RR_BACKUP_PARITY_EN define.
module rr_backup_buffer #(
  parameter int NumCores   = 8,
  parameter int NumWrPorts = 2,
  parameter int Depth      = 2,
  parameter int DataWidth  = 32,
  localparam int CoreW     = (NumCores > 1) ? $clog2(NumCores) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumCores-1:0]                    backup_en_i,
  input  logic [NumCores*NumWrPorts-1:0]         rf_we_i,
  input  logic [NumCores*NumWrPorts*5-1:0]       rf_waddr_i,
  input  logic [NumCores*NumWrPorts*DataWidth-1:0] rf_wdata_i,
  input  logic [NumCores-1:0]                    pc_valid_i,
  input  logic [NumCores*DataWidth-1:0]          pc_i,
  input  logic                                   recover_req_i,
  input  logic [CoreW-1:0]                       recover_core_i,
  output logic                                   recover_busy_o,
  output logic                                   rec_valid_o,
  input  logic                                   rec_ready_i,
  output logic [4:0]                             rec_addr_o,
  output logic [DataWidth-1:0]                   rec_data_o,
  output logic                                   rec_is_pc_o,
  output logic                                   rec_done_o,
  output logic                                   rec_err_o
);

  // state     | meaning
  // IDLE      | waiting for a recovery request
  // FLUSH     | drop uncommitted writes of the target core
  // REPLAY_RF | stream shadow x1..x31
  // REPLAY_PC | stream shadow PC
  // DONE      | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, FLUSH, REPLAY_RF, REPLAY_PC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CoreW-1:0] core_q, core_d;
  logic [4:0]       idx_q, idx_d;
  logic             start;
  logic [NumCores-1:0] blocked;

  logic                 pipe_we   [NumCores][Depth][NumWrPorts];
  logic [4:0]           pipe_addr [NumCores][Depth][NumWrPorts];
  logic [DataWidth-1:0] pipe_data [NumCores][Depth][NumWrPorts];
  logic                 pipe_pc_v [NumCores][Depth];
  logic [DataWidth-1:0] pipe_pc   [NumCores][Depth];

  logic [DataWidth-1:0] shadow_rf [NumCores][31];
  logic [DataWidth-1:0] shadow_pc [NumCores];

`ifdef RR_BACKUP_PARITY_EN
  logic shadow_par    [NumCores][31];
  logic shadow_pc_par [NumCores];
  logic beat_par;
  logic err_q;
`endif

  assign start = (state_q == IDLE) && recover_req_i && (32'(recover_core_i) < NumCores);

  // The target core neither captures nor commits while a recovery is in flight.
  always_comb begin
    for (int c = 0; c < NumCores; c++) begin
      blocked[c] = (state_q != IDLE) && (32'(core_q) == c);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumCores; c++) begin
        for (int s = 0; s < Depth; s++) begin
          pipe_pc_v[c][s] <= 1'b0;
          for (int p = 0; p < NumWrPorts; p++) pipe_we[c][s][p] <= 1'b0;
        end
        shadow_pc[c] <= '0;
        for (int w = 0; w < 31; w++) shadow_rf[c][w] <= '0;
`ifdef RR_BACKUP_PARITY_EN
        shadow_pc_par[c] <= 1'b0;
        for (int w = 0; w < 31; w++) shadow_par[c][w] <= 1'b0;
`endif
      end
    end else begin
      for (int c = 0; c < NumCores; c++) begin
        if (!blocked[c]) begin
          // Ascending port order lets the highest port win on an address clash.
          for (int p = 0; p < NumWrPorts; p++) begin
            if (pipe_we[c][Depth-1][p] && (pipe_addr[c][Depth-1][p] != 5'd0)) begin
              shadow_rf[c][pipe_addr[c][Depth-1][p] - 5'd1] <= pipe_data[c][Depth-1][p];
`ifdef RR_BACKUP_PARITY_EN
              shadow_par[c][pipe_addr[c][Depth-1][p] - 5'd1] <= ^pipe_data[c][Depth-1][p];
`endif
            end
          end
          if (pipe_pc_v[c][Depth-1]) begin
            shadow_pc[c] <= pipe_pc[c][Depth-1];
`ifdef RR_BACKUP_PARITY_EN
            shadow_pc_par[c] <= ^pipe_pc[c][Depth-1];
`endif
          end
        end
        for (int s = Depth - 1; s > 0; s--) begin
          pipe_pc_v[c][s] <= pipe_pc_v[c][s-1] && !blocked[c];
          for (int p = 0; p < NumWrPorts; p++) pipe_we[c][s][p] <= pipe_we[c][s-1][p] && !blocked[c];
        end
        pipe_pc_v[c][0] <= pc_valid_i[c] && backup_en_i[c] && !blocked[c];
        for (int p = 0; p < NumWrPorts; p++) begin
          pipe_we[c][0][p] <= rf_we_i[c*NumWrPorts+p] && backup_en_i[c] && !blocked[c];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NumCores; c++) begin
      for (int s = Depth - 1; s > 0; s--) begin
        pipe_pc[c][s] <= pipe_pc[c][s-1];
        for (int p = 0; p < NumWrPorts; p++) begin
          pipe_addr[c][s][p] <= pipe_addr[c][s-1][p];
          pipe_data[c][s][p] <= pipe_data[c][s-1][p];
        end
      end
      pipe_pc[c][0] <= pc_i[c*DataWidth +: DataWidth];
      for (int p = 0; p < NumWrPorts; p++) begin
        pipe_addr[c][0][p] <= rf_waddr_i[(c*NumWrPorts+p)*5 +: 5];
        pipe_data[c][0][p] <= rf_wdata_i[(c*NumWrPorts+p)*DataWidth +: DataWidth];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      core_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    core_d  = core_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FLUSH;
          core_d  = recover_core_i;
        end
      end
      FLUSH: begin
        state_d = REPLAY_RF;
        idx_d   = 5'd1;
      end
      REPLAY_RF: begin
        if (rec_ready_i) begin
          if (idx_q == 5'd31) state_d = REPLAY_PC;
          else idx_d = idx_q + 5'd1;
        end
      end
      REPLAY_PC: begin
        if (rec_ready_i) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign recover_busy_o = (state_q != IDLE);
  assign rec_valid_o    = (state_q == REPLAY_RF) || (state_q == REPLAY_PC);
  assign rec_is_pc_o    = (state_q == REPLAY_PC);
  assign rec_done_o     = (state_q == DONE);
  assign rec_addr_o     = (state_q == REPLAY_RF) ? idx_q : 5'd0;

  always_comb begin
    rec_data_o = '0;
`ifdef RR_BACKUP_PARITY_EN
    beat_par = 1'b0;
`endif
    if (state_q == REPLAY_RF) begin
      rec_data_o = shadow_rf[core_q][idx_q - 5'd1];
`ifdef RR_BACKUP_PARITY_EN
      beat_par = shadow_par[core_q][idx_q - 5'd1];
`endif
    end else if (state_q == REPLAY_PC) begin
      rec_data_o = shadow_pc[core_q];
`ifdef RR_BACKUP_PARITY_EN
      beat_par = shadow_pc_par[core_q];
`endif
    end
  end

`ifdef RR_BACKUP_PARITY_EN
  // Sticky until the next recovery leaves IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (start) begin
      err_q <= 1'b0;
    end else if (rec_valid_o && rec_ready_i && ((^rec_data_o) != beat_par)) begin
      err_q <= 1'b1;
    end
  end
  assign rec_err_o = err_q;
`else
  assign rec_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rr_backup_buffer.sv
// Directed self-checking bench for rr_backup_buffer (default parameters).
module tb_rr_backup_buffer;
  localparam int NC = 8;
  localparam int NP = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [NC-1:0]      backup_en;
  logic [NC*NP-1:0]   rf_we;
  logic [NC*NP*5-1:0] rf_waddr;
  logic [NC*NP*DW-1:0] rf_wdata;
  logic [NC-1:0]      pc_valid;
  logic [NC*DW-1:0]   pc;
  logic               recover_req;
  logic [2:0]         recover_core;
  logic               recover_busy, rec_valid, rec_ready, rec_is_pc, rec_done, rec_err;
  logic [4:0]         rec_addr;
  logic [DW-1:0]      rec_data;

  rr_backup_buffer dut (
    .clk_i(clk), .rst_ni(rst_n), .backup_en_i(backup_en), .rf_we_i(rf_we),
    .rf_waddr_i(rf_waddr), .rf_wdata_i(rf_wdata), .pc_valid_i(pc_valid), .pc_i(pc),
    .recover_req_i(recover_req), .recover_core_i(recover_core),
    .recover_busy_o(recover_busy), .rec_valid_o(rec_valid), .rec_ready_i(rec_ready),
    .rec_addr_o(rec_addr), .rec_data_o(rec_data), .rec_is_pc_o(rec_is_pc),
    .rec_done_o(rec_done), .rec_err_o(rec_err)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] rep_data [32];
  logic [31:0] rep_pc;
  int rep_cnt, done_cyc, err_beat;
  bit order_bad, stable_bad, busy_seen, err_seen_any;

  task automatic tick();
    @(posedge clk);
    #1;
    rf_we    = '0;
    pc_valid = '0;
  endtask

  task automatic set_wr(input int c, input int p, input logic [4:0] a, input logic [31:0] d);
    rf_we[c*NP+p] = 1'b1;
    rf_waddr[(c*NP+p)*5 +: 5] = a;
    rf_wdata[(c*NP+p)*DW +: DW] = d;
  endtask

  task automatic set_pc(input int c, input logic [31:0] v);
    pc_valid[c] = 1'b1;
    pc[c*DW +: DW] = v;
  endtask

  // Runs one recovery and records the beats; mode 1 applies ready pattern 1,0,0,1.
  task automatic do_recover(input int core, input int mode, input bit inject);
    bit prev_hold;
    logic [4:0] pa;
    logic [31:0] pd;
    logic pp;
    int cyc;
    for (int i = 0; i < 32; i++) rep_data[i] = 'x;
    rep_pc = 'x; rep_cnt = 0; done_cyc = 0; err_beat = -1;
    order_bad = 0; stable_bad = 0; prev_hold = 0;
    pa = '0; pd = '0; pp = 1'b0;
    recover_req = 1'b1; recover_core = core[2:0]; rec_ready = 1'b1; cyc = 1;
    tick();
    recover_req = 1'b0; cyc = 2;
    busy_seen = recover_busy;
    while (cyc < 400 && done_cyc == 0) begin
      rec_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (inject && cyc == 5) begin
        set_wr(3, 0, 5'd9, 32'h42);
        set_pc(3, 32'h100);
      end
      if (inject && cyc == 7) begin
        recover_req = 1'b1; recover_core = 3'd5;
      end
      if (prev_hold && (rec_addr !== pa || rec_data !== pd || rec_is_pc !== pp)) stable_bad = 1;
      if (rec_err === 1'b1 && err_beat < 0) err_beat = rep_cnt;
      if (rec_err !== 1'b0) err_seen_any = 1;
      if (rec_valid && rec_ready) begin
        if (rep_cnt < 31) begin
          if (rec_addr !== 5'(rep_cnt + 1) || rec_is_pc !== 1'b0) order_bad = 1;
          else rep_data[rec_addr] = rec_data;
        end else if (rep_cnt == 31) begin
          if (rec_addr !== 5'd0 || rec_is_pc !== 1'b1) order_bad = 1;
          else rep_pc = rec_data;
        end else begin
          order_bad = 1;
        end
        rep_cnt++;
      end
      prev_hold = rec_valid && !rec_ready;
      pa = rec_addr; pd = rec_data; pp = rec_is_pc;
      if (rec_done === 1'b1) done_cyc = cyc;
      tick();
      recover_req = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; recover_req = 1'b1; recover_core = 3'd0;
    tick(); tick();
    tests++; if (recover_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", recover_busy); end
    tests++; if (rec_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", rec_valid); end
    tests++; if (rec_done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", rec_done); end
    tests++; if (rec_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", rec_err); end
    tests++; if (rec_addr !== 5'd0) begin fails++; $display("FAIL reset_addr got=%0d exp=0", rec_addr); end
    tests++; if (rec_data !== 32'd0) begin fails++; $display("FAIL reset_data got=%h exp=0", rec_data); end
    tests++; if (rec_is_pc !== 1'b0) begin fails++; $display("FAIL reset_is_pc got=%b exp=0", rec_is_pc); end
    recover_req = 1'b0; rst_n = 1'b1;
    tick();
    tests++; if (recover_busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy got=%b exp=0", recover_busy); end
  endtask

  task automatic test_commit();
    set_wr(0, 0, 5'd5, 32'hDEAD_BEEF);
    tick(); tick(); tick();
    do_recover(0, 0, 0);
    tests++; if (busy_seen !== 1'b1) begin fails++; $display("FAIL commit_busy got=%b exp=1", busy_seen); end
    tests++; if (rep_data[5] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL commit_x5 got=%h exp=deadbeef", rep_data[5]); end
    tests++; if (rep_data[6] !== 32'd0) begin fails++; $display("FAIL commit_x6 got=%h exp=0", rep_data[6]); end
    tests++; if (rep_pc !== 32'd0) begin fails++; $display("FAIL commit_pc got=%h exp=0", rep_pc); end
    tests++; if (rep_cnt !== 32) begin fails++; $display("FAIL commit_beats got=%0d exp=32", rep_cnt); end
    tests++; if (order_bad !== 1'b0) begin fails++; $display("FAIL commit_order got=%b exp=0", order_bad); end
    tests++; if (done_cyc !== 35) begin fails++; $display("FAIL commit_latency got=%0d exp=35", done_cyc); end
    tests++; if (rec_done !== 1'b0 || recover_busy !== 1'b0) begin fails++; $display("FAIL commit_done_pulse got=%b/%b exp=0/0", rec_done, recover_busy); end
  endtask

  task automatic test_flush();
    set_wr(1, 0, 5'd7, 32'h1111);
    tick();
    do_recover(1, 0, 0);
    tests++; if (rep_data[7] !== 32'd0) begin fails++; $display("FAIL flush_x7 got=%h exp=0", rep_data[7]); end
    tick(); tick(); tick();
    do_recover(1, 0, 0);
    tests++; if (rep_data[7] !== 32'd0) begin fails++; $display("FAIL flush_x7_later got=%h exp=0", rep_data[7]); end
  endtask

  task automatic test_port_priority();
    int nz;
    set_wr(4, 0, 5'd3, 32'hA);
    set_wr(4, 1, 5'd3, 32'hB);
    tick();
    set_wr(4, 1, 5'd0, 32'hFF);
    tick(); tick(); tick();
    do_recover(4, 0, 0);
    tests++; if (rep_data[3] !== 32'hB) begin fails++; $display("FAIL prio_x3 got=%h exp=b", rep_data[3]); end
    nz = 0;
    for (int i = 1; i < 32; i++) if (i != 3 && rep_data[i] !== 32'd0) nz++;
    tests++; if (nz !== 0) begin fails++; $display("FAIL x0_trace got=%0d nonzero words exp=0", nz); end
    tests++; if (rep_pc !== 32'd0) begin fails++; $display("FAIL x0_pc got=%h exp=0", rep_pc); end
  endtask

  task automatic test_backpressure();
    do_recover(0, 1, 0);
    tests++; if (rep_cnt !== 32) begin fails++; $display("FAIL bp_beats got=%0d exp=32", rep_cnt); end
    tests++; if (order_bad !== 1'b0) begin fails++; $display("FAIL bp_order got=%b exp=0", order_bad); end
    tests++; if (stable_bad !== 1'b0) begin fails++; $display("FAIL bp_stable got=%b exp=0", stable_bad); end
    tests++; if (rep_data[5] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bp_x5 got=%h exp=deadbeef", rep_data[5]); end
    tests++; if (done_cyc == 0) begin fails++; $display("FAIL bp_done got=%0d exp=nonzero", done_cyc); end
  endtask

  task automatic test_multi_core();
    do_recover(2, 0, 1);
    tests++; if (done_cyc !== 35) begin fails++; $display("FAIL multi_latency got=%0d exp=35", done_cyc); end
    tests++; if (recover_busy !== 1'b0) begin fails++; $display("FAIL busy_req_ignored got=%b exp=0", recover_busy); end
    tick();
    tests++; if (recover_busy !== 1'b0) begin fails++; $display("FAIL busy_req_ignored2 got=%b exp=0", recover_busy); end
    do_recover(3, 0, 0);
    tests++; if (rep_data[9] !== 32'h42) begin fails++; $display("FAIL other_core_x9 got=%h exp=42", rep_data[9]); end
    tests++; if (rep_pc !== 32'h100) begin fails++; $display("FAIL other_core_pc got=%h exp=100", rep_pc); end
  endtask

  task automatic test_enable();
    backup_en[6] = 1'b0;
    set_wr(6, 0, 5'd2, 32'h77);
    set_pc(6, 32'h55);
    tick();
    backup_en[6] = 1'b1;
    tick(); tick(); tick();
    do_recover(6, 0, 0);
    tests++; if (rep_data[2] !== 32'd0) begin fails++; $display("FAIL enable_x2 got=%h exp=0", rep_data[2]); end
    tests++; if (rep_pc !== 32'd0) begin fails++; $display("FAIL enable_pc got=%h exp=0", rep_pc); end
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    recover_req = 1'b1; recover_core = 3'd0;
    tick();
    recover_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    tests++; if (recover_busy !== 1'b0 || rec_valid !== 1'b0) begin fails++; $display("FAIL abort_idle got=%b/%b exp=0/0", recover_busy, rec_valid); end
    tick();
    rst_n = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (rec_done !== 1'b0) saw_done = 1;
      tick();
    end
    tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL abort_no_done got=%b exp=0", saw_done); end
    do_recover(0, 0, 0);
    tests++; if (rep_data[5] !== 32'd0) begin fails++; $display("FAIL reset_clears_shadow got=%h exp=0", rep_data[5]); end
  endtask

`ifdef RR_BACKUP_PARITY_EN
  task automatic test_parity();
    set_wr(7, 0, 5'd10, 32'h5);
    tick(); tick(); tick(); tick();
    dut.shadow_rf[7][9] = dut.shadow_rf[7][9] ^ 32'h1;
    do_recover(7, 0, 0);
    tests++; if (err_beat !== 10) begin fails++; $display("FAIL parity_err_beat got=%0d exp=10", err_beat); end
    tests++; if (rec_err !== 1'b1) begin fails++; $display("FAIL parity_sticky got=%b exp=1", rec_err); end
    do_recover(0, 0, 0);
    tests++; if (err_beat !== -1) begin fails++; $display("FAIL parity_clear got=%0d exp=-1", err_beat); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; backup_en = '1; rf_we = '0; rf_waddr = '0; rf_wdata = '0;
    pc_valid = '0; pc = '0; recover_req = 1'b0; recover_core = '0; rec_ready = 1'b1;
    err_seen_any = 0;
    test_reset();
    test_commit();
    test_flush();
    test_port_priority();
    test_backpressure();
    test_multi_core();
    test_enable();
    test_reset_abort();
`ifdef RR_BACKUP_PARITY_EN
    test_parity();
`else
    tests++; if (err_seen_any !== 1'b0) begin fails++; $display("FAIL err_tied_low got=%b exp=0", err_seen_any); end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
